// File: rtl/jpc_bram_arbiter_pkg.sv
// Shared definitions for the JPC BRAM arbiter: bus width, out-of-range read value,
// FSM encodings and the types built on them.
`ifndef JPC_BRAM_ARB_DEFINES
`define JPC_BRAM_ARB_DEFINES
`define JPC_ADDRESS_WIDTH 32
`define JPC_MEM_DEFAULT_VALUE 32'hBAD0_BAD0
`define JPC_ST_IDLE 2'b00
`define JPC_ST_SERVE 2'b01
`define JPC_ST_INIT 2'b10
`endif

package jpc_bram_arbiter_pkg;

  localparam int ADDR_W = `JPC_ADDRESS_WIDTH;

  typedef logic [ADDR_W-1:0] word_t;

  localparam word_t MEM_DEFAULT = `JPC_MEM_DEFAULT_VALUE;

  typedef enum logic [1:0] {
    IDLE  = `JPC_ST_IDLE,
    SERVE = `JPC_ST_SERVE,
    INIT  = `JPC_ST_INIT
  } arb_state_e;

endpackage

// File: rtl/jpc_bram_arbiter_if.sv
// Requester-side bus of the arbiter: fetch port, data port and memory-fill controls.
interface jpc_bram_arbiter_if;
  import jpc_bram_arbiter_pkg::*;

  logic  f_req;
  word_t f_addr;
  logic  f_gnt;
  logic  f_rvalid;
  word_t f_rdata;

  logic  d_req;
  logic  d_we;
  word_t d_addr;
  word_t d_wdata;
  logic  d_gnt;
  logic  d_rvalid;
  word_t d_rdata;
  logic  d_err;

  logic  init_start;
  word_t init_value;
  logic  init_busy;
  logic  init_done;

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, init_start, init_value,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, d_err, init_busy, init_done
  );

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, init_start, init_value,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, d_err, init_busy, init_done
  );

endinterface

// File: rtl/jpc_32bram.sv
// Single-port 32-bit block RAM with a registered read port (one cycle read latency).
module jpc_32bram
  import jpc_bram_arbiter_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  word_t         din,
  input  logic          we,
  output word_t         dout
);

  word_t mem [DEPTH];

  // No reset on the array so synthesis can map it onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/jpc_bram_arbiter.sv
// Arbitrates a fetch port and a data port onto one jpc_32bram and fills the RAM on request.
// Define JPC_BRAM_ARB_RR_EN for weighted round-robin; otherwise data has fixed priority.
module jpc_bram_arbiter
  import jpc_bram_arbiter_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int RR_WEIGHT = 1
) (
  input logic               clk,
  input logic               rst_n,
  jpc_bram_arbiter_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(RR_WEIGHT + 1) + 1;
`ifdef JPC_BRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  arb_state_e    state, state_nxt;
  logic [AW-1:0] init_cnt;
  word_t         init_word;
  logic          init_done_q;
  logic [CW-1:0] rr_cnt;
  logic          f_rvalid_q, d_rvalid_q, f_oor_q, d_oor_q;

  logic          init_go, init_last, rr_force, f_oor, d_oor, f_gnt, d_gnt;
  logic [AW-1:0] ram_addr;
  word_t         ram_din, ram_dout;
  logic          ram_we;

  assign f_oor     = bus.f_addr >= word_t'(DEPTH);
  assign d_oor     = bus.d_addr >= word_t'(DEPTH);
  assign init_go   = bus.init_start && (state != INIT);
  assign init_last = init_cnt == AW'(DEPTH - 1);
  assign rr_force  = RR_EN && (rr_cnt >= CW'(RR_WEIGHT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grants are combinational so a requester can be served in the cycle it asks;
  // a fill request in the same cycle takes precedence over both ports.
  always_comb begin
    state_nxt = state;
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
    ram_addr  = init_cnt;
    ram_din   = init_word;
    ram_we    = 1'b0;
    unique case (state)
      INIT: begin
        ram_we = 1'b1;
        if (init_last) state_nxt = IDLE;
      end
      default: begin
        if (init_go) begin
          state_nxt = INIT;
        end else begin
          state_nxt = (bus.f_req || bus.d_req) ? SERVE : IDLE;
          if (bus.d_req && !(bus.f_req && rr_force)) d_gnt = 1'b1;
          else if (bus.f_req)                       f_gnt = 1'b1;
          if (d_gnt) begin
            ram_addr = bus.d_addr[AW-1:0];
            ram_din  = bus.d_wdata;
            ram_we   = bus.d_we && !d_oor;
          end else if (f_gnt) begin
            ram_addr = bus.f_addr[AW-1:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt    <= '0;
      init_word   <= '0;
      init_done_q <= 1'b0;
    end else if (init_go) begin
      init_cnt    <= '0;
      init_word   <= bus.init_value;
      init_done_q <= 1'b0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + AW'(1);
      if (init_last) init_done_q <= 1'b1;
    end
  end

  // Counts data grants taken while fetch was waiting; only meaningful in round-robin builds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_cnt <= '0;
    end else if (f_gnt) begin
      rr_cnt <= '0;
    end else if (d_gnt) begin
      if (!bus.f_req)                   rr_cnt <= '0;
      else if (rr_cnt < CW'(RR_WEIGHT)) rr_cnt <= rr_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_oor_q    <= 1'b0;
      d_oor_q    <= 1'b0;
    end else begin
      f_rvalid_q <= f_gnt;
      d_rvalid_q <= d_gnt && !bus.d_we;
      f_oor_q    <= f_gnt && f_oor;
      d_oor_q    <= d_gnt && d_oor;
    end
  end

  jpc_32bram #(.DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .din  (ram_din),
    .we   (ram_we),
    .dout (ram_dout)
  );

  assign bus.f_gnt     = f_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.f_rvalid  = f_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_err     = d_oor_q;
  assign bus.f_rdata   = f_rvalid_q ? (f_oor_q ? MEM_DEFAULT : ram_dout) : '0;
  assign bus.d_rdata   = d_rvalid_q ? (d_oor_q ? MEM_DEFAULT : ram_dout) : '0;
  assign bus.init_busy = state == INIT;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_jpc_bram_arbiter.sv
// Self-checking bench for jpc_bram_arbiter against an array-based memory/arbitration model.
// Honours JPC_BRAM_ARB_RR_EN when deciding which port should win a tie.
module tb_jpc_bram_arbiter;
  import jpc_bram_arbiter_pkg::*;

  localparam int DEPTH     = 256;
  localparam int RR_WEIGHT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jpc_bram_arbiter_if bus ();

  jpc_bram_arbiter #(.DEPTH(DEPTH), .RR_WEIGHT(RR_WEIGHT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  word_t mem_m [DEPTH];
  bit    known [DEPTH];
  int    init_left;
  bit    done_m;
  word_t init_val_m;
  int    streak;
  bit    g_f, g_d;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelRead(input word_t a, output word_t d, output bit k);
    if (a >= DEPTH) begin
      d = MEM_DEFAULT;
      k = 1'b1;
    end else begin
      d = mem_m[a];
      k = known[a];
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    init_left = 0;
    done_m    = 1'b0;
    streak    = 0;
  endtask

  // One clock cycle: drive at posedge+1, check grants at negedge, check read results at next posedge+1.
  task automatic applyStimulus(input bit fr, input word_t fa, input bit dr, input bit dwe,
                               input word_t da, input word_t dwd, input bit is, input word_t iv,
                               output bit fg, output bit dg);
    bit    exp_fv, exp_dv, exp_de, exp_fk, exp_dk;
    word_t exp_fd, exp_dd;
    bus.f_req = fr;  bus.f_addr = fa;
    bus.d_req = dr;  bus.d_we = dwe;  bus.d_addr = da;  bus.d_wdata = dwd;
    bus.init_start = is;  bus.init_value = iv;
    fg = 1'b0;
    dg = 1'b0;
    if (init_left == 0 && !is) begin
      if (fr && dr) begin
`ifdef JPC_BRAM_ARB_RR_EN
        if (streak >= RR_WEIGHT) fg = 1'b1;
        else                     dg = 1'b1;
`else
        dg = 1'b1;
`endif
      end else begin
        fg = fr;
        dg = dr;
      end
    end
    @(negedge clk);
    checkOutput("f_gnt", bus.f_gnt, fg);
    checkOutput("d_gnt", bus.d_gnt, dg);
    checkOutput("init_busy", bus.init_busy, init_left > 0);
    checkOutput("init_done", bus.init_done, done_m);
    @(posedge clk);
    exp_fv = 1'b0;  exp_dv = 1'b0;  exp_de = 1'b0;
    exp_fk = 1'b0;  exp_dk = 1'b0;
    exp_fd = '0;    exp_dd = '0;
    if (init_left > 0) begin
      init_left--;
      if (init_left == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_m[i] = init_val_m;
          known[i] = 1'b1;
        end
        done_m = 1'b1;
      end
    end else if (is) begin
      init_left  = DEPTH;
      init_val_m = iv;
      done_m     = 1'b0;
    end else begin
      if (fg) begin
        exp_fv = 1'b1;
        modelRead(fa, exp_fd, exp_fk);
        streak = 0;
      end
      if (dg) begin
        streak = fr ? streak + 1 : 0;
        exp_de = da >= DEPTH;
        if (dwe) begin
          if (da < DEPTH) begin
            mem_m[da] = dwd;
            known[da] = 1'b1;
          end
        end else begin
          exp_dv = 1'b1;
          modelRead(da, exp_dd, exp_dk);
        end
      end
    end
    #1;
    checkOutput("f_rvalid", bus.f_rvalid, exp_fv);
    checkOutput("d_rvalid", bus.d_rvalid, exp_dv);
    checkOutput("d_err", bus.d_err, exp_de);
    if (exp_fv && exp_fk) checkOutput("f_rdata", bus.f_rdata, exp_fd);
    if (exp_dv && exp_dk) checkOutput("d_rdata", bus.d_rdata, exp_dd);
  endtask

  task automatic idleCycle();
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0, g_f, g_d);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " f_gnt"}, bus.f_gnt, 0);
    checkOutput({tag, " d_gnt"}, bus.d_gnt, 0);
    checkOutput({tag, " f_rvalid"}, bus.f_rvalid, 0);
    checkOutput({tag, " d_rvalid"}, bus.d_rvalid, 0);
    checkOutput({tag, " d_err"}, bus.d_err, 0);
    checkOutput({tag, " init_busy"}, bus.init_busy, 0);
    checkOutput({tag, " init_done"}, bus.init_done, 0);
    checkOutput({tag, " f_rdata"}, bus.f_rdata, 0);
    checkOutput({tag, " d_rdata"}, bus.d_rdata, 0);
  endtask

  initial begin
    bit    pf, pd, pwe;
    word_t pfa, pda, pwd;

    bus.f_req = 0;  bus.f_addr = '0;
    bus.d_req = 0;  bus.d_we = 0;  bus.d_addr = '0;  bus.d_wdata = '0;
    bus.init_start = 0;  bus.init_value = '0;
    modelReset();

    #2;
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] directed accesses");
    applyStimulus(1, 32'd7, 0, 0, '0, '0, 0, '0, g_f, g_d);
    applyStimulus(0, '0, 1, 1, 32'd5, 32'hDEADBEEF, 0, '0, g_f, g_d);
    applyStimulus(1, 32'd5, 0, 0, '0, '0, 0, '0, g_f, g_d);
    applyStimulus(0, '0, 1, 0, 32'd300, '0, 0, '0, g_f, g_d);
    applyStimulus(1, 32'd999, 0, 0, '0, '0, 0, '0, g_f, g_d);
    applyStimulus(0, '0, 1, 1, 32'd256, 32'h11112222, 0, '0, g_f, g_d);
    applyStimulus(0, '0, 1, 1, 32'd1, 32'h0000_0111, 0, '0, g_f, g_d);

    $display("[TB] contention");
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 32'd5, 1, 0, 32'd1, '0, 0, '0, g_f, g_d);

    $display("[TB] memory fill");
    applyStimulus(0, '0, 1, 0, 32'd5, '0, 0, '0, g_f, g_d);
    applyStimulus(1, 32'd3, 0, 0, '0, '0, 1, 32'h12345678, g_f, g_d);
    for (int i = 1; i <= DEPTH; i++)
      applyStimulus(1, 32'd3, 1, 0, 32'd4, '0, i == 50, 32'hFFFF0000, g_f, g_d);
    idleCycle();
    applyStimulus(0, '0, 1, 0, 32'd255, '0, 0, '0, g_f, g_d);
    applyStimulus(1, 32'd0, 0, 0, '0, '0, 0, '0, g_f, g_d);

    $display("[TB] random traffic");
    pf = 0;  pd = 0;  pwe = 0;  pfa = '0;  pda = '0;  pwd = '0;
    for (int i = 0; i < 300; i++) begin
      if (!pf && $urandom_range(0, 9) < 7) begin
        pf  = 1'b1;
        pfa = word_t'($urandom_range(0, DEPTH + 40));
      end
      if (!pd && $urandom_range(0, 9) < 7) begin
        pd  = 1'b1;
        pwe = 1'($urandom_range(0, 1));
        pda = word_t'($urandom_range(0, DEPTH + 40));
        pwd = word_t'($urandom);
      end
      applyStimulus(pf, pfa, pd, pwe, pda, pwd, 0, '0, g_f, g_d);
      if (g_f) pf = 1'b0;
      if (g_d) pd = 1'b0;
    end
    idleCycle();

    $display("[TB] reset during fill");
    applyStimulus(0, '0, 0, 0, '0, '0, 1, 32'hA5A5A5A5, g_f, g_d);
    for (int i = 1; i < 100; i++) idleCycle();
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("async reset");
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 32'd0, 0, 0, '0, '0, 0, '0, g_f, g_d);
    applyStimulus(0, '0, 1, 1, 32'd9, 32'hCAFEF00D, 0, '0, g_f, g_d);
    applyStimulus(1, 32'd9, 0, 0, '0, '0, 0, '0, g_f, g_d);
    idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jpc_bram_arbiter.md
JPC_BRAM_ARBITER -- requirements
Module: jpc_bram_arbiter

Interface
REQ-001 Parameters SHALL be: DEPTH, default 256, word count of the shared RAM; RR_WEIGHT, default 1, consecutive data grants allowed before fetch is forced (round-robin mode only).
REQ-002 Ports SHALL be, clock and reset first: clk  in  1  sole clock, all logic on rising edge; rst_n  in  1  asynchronous, active-low reset.
REQ-003 Fetch port SHALL be: f_req in 1 read request; f_addr in `JPC_ADDRESS_WIDTH word address; f_gnt out 1 accepted this cycle; f_rvalid out 1 read data valid; f_rdata out `JPC_ADDRESS_WIDTH read data.
REQ-004 Data port SHALL be: d_req in 1; d_we in 1 write when high; d_addr in `JPC_ADDRESS_WIDTH; d_wdata in `JPC_ADDRESS_WIDTH; d_gnt out 1; d_rvalid out 1; d_rdata out `JPC_ADDRESS_WIDTH; d_err out 1 out-of-range pulse.
REQ-005 Init port SHALL be: init_start in 1 start-fill pulse; init_value in `JPC_ADDRESS_WIDTH fill word; init_busy out 1; init_done out 1 sticky until next init_start.

Function
REQ-006 Block SHALL own one jpc_32bram instance (DEPTH passed through) and be its only driver of addr/din/we.
REQ-007 FSM states SHALL be IDLE, SERVE, INIT; IDLE->SERVE on any req; SERVE->IDLE when no req; IDLE/SERVE->INIT on init_start; INIT->IDLE after final word written.
REQ-008 At most one grant SHALL assert per cycle; grant is combinational from req in IDLE/SERVE; a request is consumed when req && gnt at a clock edge.
REQ-009 Requesters SHALL hold req/addr/we/wdata stable until granted.
REQ-010 Read data SHALL appear with rvalid exactly 1 cycle after the granted edge, on the port that was granted; rvalid SHALL NOT assert for writes.
REQ-011 Back-to-back grants SHALL be sustained: one access per cycle, full throughput.
REQ-012 Fixed-priority mode: data SHALL win over fetch when both request.
REQ-013 Address >= DEPTH SHALL be granted, write suppressed, read returns `JPC_MEM_DEFAULT_VALUE, d_err pulses 1 cycle with rvalid timing (fetch: data only, no error output).
REQ-014 INIT SHALL write init_value to addresses 0..DEPTH-1, one per cycle, init_busy high throughout, no grants; init_value sampled at init_start.
REQ-015 init_done SHALL rise the cycle after the last write (DEPTH+1 cycles after init_start) and clear on the next init_start.
REQ-016 init_start while init_busy SHALL be ignored; init_start same cycle as a req SHALL win, req not granted.
REQ-017 A read granted the cycle before INIT entry SHALL still return its rvalid.

Reset
REQ-018 On rst_n low, asynchronously: FSM=IDLE, all gnt/rvalid/err/init_busy/init_done=0, rdata=0, init counter=0, RR pointer=fetch-last (data wins first tie).
REQ-019 Reset mid-INIT SHALL abort the fill; init_done stays 0; RAM contents are undefined.
REQ-020 First grant SHALL be possible in the first cycle after rst_n deasserts.

Configuration
REQ-021 Macro JPC_BRAM_ARB_RR_EN defined: round-robin; after RR_WEIGHT consecutive data grants with fetch pending, fetch SHALL be granted next; a fetch grant resets the count.
REQ-022 Macro undefined: fixed priority per REQ-012; RR_WEIGHT ignored; fetch may starve.

Structure
REQ-023 Shared defines header SHALL hold `JPC_ADDRESS_WIDTH, `JPC_MEM_DEFAULT_VALUE and FSM state encodings (2 bits).
REQ-024 Sub-module: jpc_32bram only; arbitration, FSM and init counter live in jpc_bram_arbiter.

Verification
REQ-025 Data write addr 5 = 0xDEADBEEF, then fetch addr 5 -> f_rvalid 1 cycle after f_gnt, f_rdata=0xDEADBEEF, d_rvalid never high.
REQ-026 Both req continuously, RR_EN, RR_WEIGHT=1 -> grants alternate D,F,D,F; without macro -> D every cycle, f_gnt 0.
REQ-027 init_start with init_value=0x12345678, DEPTH=256 -> init_busy 256 cycles, no grants, init_done on cycle 257; read addr 255 = 0x12345678.
REQ-028 Data read addr 300 (DEPTH=256) -> d_gnt, next cycle d_rvalid=1, d_err=1, d_rdata=`JPC_MEM_DEFAULT_VALUE.
REQ-029 rst_n low at init cycle 100 -> outputs 0 immediately, init_done 0; after release, fetch addr 0 granted first cycle.
REQ-030 init_start at init cycle 50 -> ignored, init_done still on cycle 257.
